// File: rtl/chess_clock_controller.sv
// Two-sided chess clock scheduler. One shared 1 Hz prescaler drives the
// countdown of the side to move. Also handles pause, per-move increment and
// flag-fall. Every time value is kept as BCD M:SS, from 0:00 to 9:59.
module chess_clock_controller #(
  parameter int TICK_DIV    = 50000000,
  parameter int START_MINS  = 5,
  parameter int START_TENS  = 0,
  parameter int START_UNITS = 0,
  parameter int INCREMENT   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       player,
  input  logic       checkmate,
  output logic [3:0] whiteMins,
  output logic [2:0] whiteTens,
  output logic [3:0] whiteUnits,
  output logic [3:0] blackMins,
  output logic [2:0] blackTens,
  output logic [3:0] blackUnits,
  output logic       whiteTimeout,
  output logic       blackTimeout,
  output logic       running,
  output logic       secondTick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [3:0] m;
    logic [2:0] t;
    logic [3:0] u;
  } bcd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PAUSE, S_INCR, S_EXPIRED, S_FROZEN
  } state_t;

  localparam bcd_t START = {4'(START_MINS), 3'(START_TENS), 4'(START_UNITS)};
  localparam bcd_t MAXV  = {4'd9, 3'd5, 4'd9};
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  // One second down with borrow. The value holds at 0:00 so that a 0:00
  // start expires cleanly and does not wrap.
  function automatic bcd_t bcd_dec(bcd_t v);
    bcd_t r;
    r = v;
    if (v.u != 4'd0) begin
      r.u = v.u - 4'd1;
    end else if (v.t != 3'd0) begin
      r.u = 4'd9;
      r.t = v.t - 3'd1;
    end else if (v.m != 4'd0) begin
      r.u = 4'd9;
      r.t = 3'd5;
      r.m = v.m - 4'd1;
    end
    return r;
  endfunction

  // One second up with carry. The value saturates at 9:59.
  function automatic bcd_t bcd_inc(bcd_t v);
    bcd_t r;
    r = v;
    if (v != MAXV) begin
      if (v.u != 4'd9) begin
        r.u = v.u + 4'd1;
      end else begin
        r.u = 4'd0;
        if (v.t != 3'd5) begin
          r.t = v.t + 3'd1;
        end else begin
          r.t = 3'd0;
          r.m = v.m + 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q;
  bcd_t          white_q, black_q;
  logic [PW-1:0] presc_q;
  logic          player_q;   // side whose clock is running
  logic          credit_q;   // side receiving the increment
  logic [3:0]    inc_cnt_q;
  logic          wto_q, bto_q, run_q, tick_q;

  bcd_t act_dec, cred_inc;
  logic act_zero;

  // Candidate values: active side one second down, credited side one second up
  always_comb begin
    act_dec  = bcd_dec(player_q ? white_q : black_q);
    act_zero = (act_dec == '0);
    cred_inc = bcd_inc(credit_q ? white_q : black_q);
  end

  // Scheduler FSM with registered digits, flags and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      white_q   <= START;
      black_q   <= START;
      presc_q   <= '0;
      player_q  <= 1'b1;
      credit_q  <= 1'b1;
      inc_cnt_q <= '0;
      wto_q     <= 1'b0;
      bto_q     <= 1'b0;
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (checkmate) begin
            state_q <= S_FROZEN;
          end else if (enable) begin
            state_q  <= S_RUN;
            player_q <= player;
            presc_q  <= '0;
            run_q    <= 1'b1;
          end
        end
        S_RUN: begin
          if (checkmate) begin
            state_q <= S_FROZEN;
            run_q   <= 1'b0;
          end else if (!enable) begin
            state_q <= S_PAUSE;
            run_q   <= 1'b0;
          end else if (player != player_q) begin
            // A turn change wins over a coincident tick, and that tick is lost.
            player_q <= player;
            presc_q  <= '0;
            if (INCREMENT > 0) begin
              state_q   <= S_INCR;
              inc_cnt_q <= 4'(INCREMENT);
              credit_q  <= player_q;
              run_q     <= 1'b0;
            end
          end else if (presc_q == PS_LAST) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            if (player_q) white_q <= act_dec;
            else          black_q <= act_dec;
            if (act_zero) begin
              state_q <= S_EXPIRED;
              run_q   <= 1'b0;
              if (player_q) wto_q <= 1'b1;
              else          bto_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          // The player input is ignored here. RUN catches any turn change on resume.
          if (checkmate) begin
            state_q <= S_FROZEN;
          end else if (enable) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        S_INCR: begin
          if (checkmate) begin
            state_q <= S_FROZEN;
          end else begin
            if (credit_q) white_q <= cred_inc;
            else          black_q <= cred_inc;
            inc_cnt_q <= inc_cnt_q - 4'd1;
            presc_q   <= '0;
            if (inc_cnt_q == 4'd1) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        default: ;  // EXPIRED / FROZEN hold until reset
      endcase
    end
  end

  assign whiteMins    = white_q.m;
  assign whiteTens    = white_q.t;
  assign whiteUnits   = white_q.u;
  assign blackMins    = black_q.m;
  assign blackTens    = black_q.t;
  assign blackUnits   = black_q.u;
  assign whiteTimeout = wto_q;
  assign blackTimeout = bto_q;
  assign running      = run_q;
  assign secondTick   = tick_q;

endmodule

// File: tb/tb_chess_clock_controller.sv
// Directed bench for chess_clock_controller. Three instances with different
// start values and increments share one stimulus stream, and each scenario
// checks only the instance it targets. Times are compared as M*100+S.
module tb_chess_clock_controller;

  logic clock = 1'b0;
  logic reset, enable, player, checkmate;

  logic [3:0] wm [3];
  logic [2:0] wt [3];
  logic [3:0] wu [3];
  logic [3:0] bm [3];
  logic [2:0] bt [3];
  logic [3:0] bu [3];
  logic       wto [3];
  logic       bto [3];
  logic       rn  [3];
  logic       st  [3];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // A: start 0:03, no increment
  chess_clock_controller #(.TICK_DIV(4), .START_MINS(0), .START_TENS(0),
    .START_UNITS(3), .INCREMENT(0)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .player(player),
    .checkmate(checkmate),
    .whiteMins(wm[0]), .whiteTens(wt[0]), .whiteUnits(wu[0]),
    .blackMins(bm[0]), .blackTens(bt[0]), .blackUnits(bu[0]),
    .whiteTimeout(wto[0]), .blackTimeout(bto[0]),
    .running(rn[0]), .secondTick(st[0]));

  // B: start 1:00, increment 2
  chess_clock_controller #(.TICK_DIV(4), .START_MINS(1), .START_TENS(0),
    .START_UNITS(0), .INCREMENT(2)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .player(player),
    .checkmate(checkmate),
    .whiteMins(wm[1]), .whiteTens(wt[1]), .whiteUnits(wu[1]),
    .blackMins(bm[1]), .blackTens(bt[1]), .blackUnits(bu[1]),
    .whiteTimeout(wto[1]), .blackTimeout(bto[1]),
    .running(rn[1]), .secondTick(st[1]));

  // C: start 9:59, increment 3
  chess_clock_controller #(.TICK_DIV(4), .START_MINS(9), .START_TENS(5),
    .START_UNITS(9), .INCREMENT(3)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .player(player),
    .checkmate(checkmate),
    .whiteMins(wm[2]), .whiteTens(wt[2]), .whiteUnits(wu[2]),
    .blackMins(bm[2]), .blackTens(bt[2]), .blackUnits(bu[2]),
    .whiteTimeout(wto[2]), .blackTimeout(bto[2]),
    .running(rn[2]), .secondTick(st[2]));

  function automatic int wtime(int i);
    return int'(wm[i]) * 100 + int'(wt[i]) * 10 + int'(wu[i]);
  endfunction

  function automatic int btime(int i);
    return int'(bm[i]) * 100 + int'(bt[i]) * 10 + int'(bu[i]);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n clock edges, then settle just past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Apply one reset edge, then release with timing enabled and white to move.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; player = 1'b1; checkmate = 1'b0;
    step(1);
    reset = 1'b0; enable = 1'b1;
  endtask

  initial begin
    int ticks;
    reset = 1'b1; enable = 1'b0; player = 1'b1; checkmate = 1'b0;
    step(2);

    // ---- reset state ----
    chk("rst_white_a", wtime(0), 3);
    chk("rst_black_a", btime(0), 3);
    chk("rst_white_c", wtime(2), 959);
    chk("rst_running", int'(rn[0]), 0);
    chk("rst_tick", int'(st[0]), 0);
    chk("rst_wto", int'(wto[0]), 0);
    chk("rst_bto", int'(bto[0]), 0);

    // ---- 1: countdown to flag-fall (A) ----
    do_reset();
    step(1);                       // IDLE -> RUN
    chk("t1_running", int'(rn[0]), 1);
    step(3);
    chk("t1_pre_tick", wtime(0), 3);
    step(1);
    chk("t1_w2", wtime(0), 2);
    chk("t1_tick_hi", int'(st[0]), 1);
    step(1);
    chk("t1_tick_lo", int'(st[0]), 0);
    step(3);
    chk("t1_w1", wtime(0), 1);
    step(4);
    chk("t1_w0", wtime(0), 0);
    chk("t1_wto", int'(wto[0]), 1);
    chk("t1_run_off", int'(rn[0]), 0);
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      ticks += int'(st[0]);
    end
    chk("t1_no_more_ticks", ticks, 0);
    chk("t1_w_hold", wtime(0), 0);
    chk("t1_black", btime(0), 3);
    chk("t1_bto", int'(bto[0]), 0);

    // ---- 2/3: tick, then turn change coincident with wrap (B) ----
    do_reset();
    step(5);
    chk("t2_w059", wtime(1), 59);
    chk("t2_tick", int'(st[1]), 1);
    step(1);
    chk("t2_tick_once", int'(st[1]), 0);
    chk("t2_black", btime(1), 100);
    step(35);                      // edge 41
    chk("t3_w050", wtime(1), 50);
    step(3);                       // prescaler now at last count
    player = 1'b0;
    step(1);                       // wrap edge lost to turn change
    chk("t3_no_dec", wtime(1), 50);
    chk("t3_incr_state", int'(rn[1]), 0);
    chk("t3_no_tick", int'(st[1]), 0);
    step(1);
    chk("t3_w051", wtime(1), 51);
    step(1);
    chk("t3_w052", wtime(1), 52);
    chk("t3_back_run", int'(rn[1]), 1);
    step(3);
    chk("t3_black_hold", btime(1), 100);
    step(1);
    chk("t3_black_dec", btime(1), 59);
    chk("t3_white_hold", wtime(1), 52);

    // ---- 4: increment saturates at 9:59 (C) ----
    do_reset();
    step(5);
    chk("t4_w958", wtime(2), 958);
    player = 1'b0;
    step(1);
    chk("t4_incr", int'(rn[2]), 0);
    step(2);
    chk("t4_sat", wtime(2), 959);
    chk("t4_still_incr", int'(rn[2]), 0);
    step(1);
    chk("t4_run", int'(rn[2]), 1);
    chk("t4_w959", wtime(2), 959);
    step(4);
    chk("t4_black_dec", btime(2), 958);

    // ---- 5: pause keeps prescaler; turn change while paused (B) ----
    do_reset();
    step(3);                       // prescaler = 2
    enable = 1'b0;
    step(10);
    chk("t5_paused", int'(rn[1]), 0);
    chk("t5_w_hold", wtime(1), 100);
    enable = 1'b1;
    step(1);
    chk("t5_resumed", int'(rn[1]), 1);
    step(1);
    chk("t5_no_tick_yet", wtime(1), 100);
    step(1);
    chk("t5_tick_tdm2", wtime(1), 59);
    enable = 1'b0;
    step(1);
    player = 1'b0;
    step(3);
    chk("t5_pause2_w", wtime(1), 59);
    chk("t5_pause2_b", btime(1), 100);
    enable = 1'b1;
    step(1);
    chk("t5_resume2", int'(rn[1]), 1);
    step(1);
    chk("t5_incr_entry", int'(rn[1]), 0);
    step(1);
    chk("t5_carry_100", wtime(1), 100);
    step(1);
    chk("t5_w101", wtime(1), 101);
    chk("t5_run_after", int'(rn[1]), 1);

    // ---- 6: checkmate on a tick freezes; reset mid-RUN reloads (A) ----
    do_reset();
    step(4);                       // next edge would tick
    checkmate = 1'b1;
    step(1);
    chk("t6_no_dec", wtime(0), 3);
    chk("t6_no_tick", int'(st[0]), 0);
    chk("t6_frozen", int'(rn[0]), 0);
    checkmate = 1'b0;
    player = 1'b0;
    step(10);
    chk("t6_w_hold", wtime(0), 3);
    chk("t6_b_hold", btime(0), 3);
    chk("t6_still_frozen", int'(rn[0]), 0);
    chk("t6_no_to", int'(wto[0]) + int'(bto[0]), 0);
    do_reset();
    step(5);
    chk("t6_pre_reset_w", wtime(0), 2);
    reset = 1'b1;
    step(1);
    chk("t6_reload_w", wtime(0), 3);
    chk("t6_reload_b", btime(0), 3);
    chk("t6_idle", int'(rn[0]), 0);
    reset = 1'b0;
    step(1);
    chk("t6_idle_to_run", int'(rn[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
